serial_deser: RTL and testbench

//  Serial-to-parallel deserializer. It sits directly downstream of the transmission-gate master-slave flip-flop stage.
//  It consumes the flop's registered Q bitstream and assembles WIDTH-bit words.

---
 rtl/deser_pkg.sv | 24 ++
 rtl/dff_arn.sv | 28 ++
 rtl/serial_deser.sv | 169 ++++++++++++++++
 tb/tb_serial_deser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deser_pkg
//  Description : Shared types and helpers for the serial_deser block.
//                deser_state_t : deserializer FSM state encoding.
//                deser_cnt_w() : bit-counter width for a given word width,
//                                $clog2(WIDTH+1).
//  Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } deser_state_t;

    // Counter width for a WIDTH-bit word.
    function automatic int deser_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : deser_pkg
`default_nettype wire

// File: rtl/dff_arn.sv
`default_nettype none
// ============================================================================
//  Module      : dff_arn
//  Description : Single-bit rising-edge flop with asynchronous active-low
//                reset, matching the upstream master-slave flop stage.
//  Ports       : Clk   in  clock
//                Rst_n in  async active-low reset (clears Q)
//                D     in  data
//                Q     out registered data
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_arn (
    input  logic Clk,
    input  logic Rst_n,
    input  logic D,
    output logic Q
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

endmodule : dff_arn
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deser
//  Description : Serial-to-parallel deserializer, LSB first. Completed words
//                are presented on a double-buffered output with Valid/Ready.
//                Shifting continues while a word waits to be consumed.
//  Config      : PARITY_EN - when defined, each frame carries one trailing
//                even-parity bit and the ParErr output is present.
//  Ports       : Clk     in  clock, rising edge
//                Rst_n   in  async active-low reset
//                D       in  serial data bit
//                DEn     in  D qualifier
//                Ready   in  consumer accepts Q on Valid&&Ready
//                Q       out last completed word (WIDTH bits)
//                Valid   out Q holds an unconsumed word
//                Overrun out one-cycle pulse: completed word dropped
//                ParErr  out parity mismatch for the word in Q (PARITY_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_deser
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             D,
    input  logic             DEn,
    input  logic             Ready,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Overrun
`ifdef PARITY_EN
    ,
    output logic             ParErr
`endif
);

    localparam int CNT_W = deser_cnt_w(WIDTH);

    deser_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] done_word;
    logic             done;
    logic             last_data;
    logic             valid_q, valid_d;
    logic             ovr_d;
`ifdef PARITY_EN
    logic             par_err_new;
    logic             par_q, par_d;
`else
    // Without a parity stage the oldest shift-register bit is never read.
    logic             unused_lsb;
    assign unused_lsb = shreg_q[0];
`endif

    assign shifted   = {D, shreg_q[WIDTH-1:1]};
    assign last_data = (cnt_q == CNT_W'(WIDTH - 1));

    // ---------------- FSM / datapath next state ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        done      = 1'b0;
        done_word = shifted;
`ifdef PARITY_EN
        par_err_new = 1'b0;
`endif
        if (DEn) begin
            case (state_q)
                IDLE, SHIFT: begin
                    shreg_d = shifted;
                    if (last_data) begin
                        cnt_d = '0;
`ifdef PARITY_EN
                        state_d = PAR;
`else
                        // Word completes on this edge, final bit included.
                        done    = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    // Parity bit is checked, not shifted into the word.
                    done        = 1'b1;
                    done_word   = shreg_q;
                    par_err_new = ^{shreg_q, D};
                    state_d     = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- output buffer / handshake ----------------
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        if (done && (!valid_q || Ready)) begin
            // Free buffer, or the pending word is consumed on this same edge.
            word_d  = done_word;
            valid_d = 1'b1;
`ifdef PARITY_EN
            par_d   = par_err_new;
`endif
        end else if (done) begin
            // Buffer still held: the new word is dropped.
            ovr_d = 1'b1;
        end else if (valid_q && Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    dff_arn u_valid_ff (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .D     (valid_d),
        .Q     (valid_q)
    );

    dff_arn u_ovr_ff (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .D     (ovr_d),
        .Q     (Overrun)
    );

    assign Q     = word_q;
    assign Valid = valid_q;
`ifdef PARITY_EN
    assign ParErr = par_q;
`endif

endmodule : serial_deser
`default_nettype wire

// File: tb/tb_serial_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deser
//  Description : Directed self-checking bench for serial_deser (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deser;

    logic       Clk;
    logic       Rst_n;
    logic       D;
    logic       DEn;
    logic       Ready;
    logic [7:0] Q;
    logic       Valid;
    logic       Overrun;
`ifdef PARITY_EN
    logic       ParErr;
`endif

    int errors = 0;
    int checks = 0;

    // Outputs sampled just before the final edge of the last send_word call.
    logic vb;
    logic ob;

    serial_deser #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .D       (D),
        .DEn     (DEn),
        .Ready   (Ready),
        .Q       (Q),
        .Valid   (Valid),
        .Overrun (Overrun)
`ifdef PARITY_EN
        ,
        .ParErr  (ParErr)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sends one frame LSB first (plus parity bit when enabled). Ready is
    // rdy for every edge except the final one, which uses rdy_last.
    // stall_at >= 0 inserts 3 DEn=0 cycles after that bit index.
    task automatic send_word(input logic [7:0] w, input logic rdy,
                             input logic rdy_last, input int stall_at,
                             input logic bad_par);
        int nb;
`ifdef PARITY_EN
        nb = 9;
`else
        nb = 8;
`endif
        for (int i = 0; i < nb; i++) begin
            D     = (i < 8) ? w[i] : ((^w) ^ bad_par);
            DEn   = 1'b1;
            Ready = (i == nb - 1) ? rdy_last : rdy;
            if (i == nb - 1) begin
                vb = Valid;
                ob = Overrun;
            end
            tick();
            if (i == stall_at) begin
                DEn = 1'b0;
                D   = ~D;
                repeat (3) tick();
            end
        end
        DEn   = 1'b0;
        Ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; D = 1'b0; DEn = 1'b0; Ready = 1'b0;
        #2;
        if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
        checks++;
        if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid); end
        checks++;
        if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", Overrun); end
        checks++;
        tick();
        #2 Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        send_word(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        if (vb !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", vb); end
        checks++;
        if (Q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected a5", Q); end
        checks++;
        if (Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", Valid); end
        checks++;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        if (Valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", Valid); end
        checks++;
        if (Q !== 8'hA5) begin errors++; $display("FAIL single_q_hold: got %h expected a5", Q); end
        checks++;
    endtask

    task automatic test_stall();
        send_word(8'hA5, 1'b1, 1'b1, 3, 1'b0);
        if (vb !== 1'b0) begin errors++; $display("FAIL stall_early_valid: got %b expected 0", vb); end
        checks++;
        if (Q !== 8'hA5 || Valid !== 1'b1) begin
            errors++; $display("FAIL stall_word: got q=%h v=%b expected q=a5 v=1", Q, Valid);
        end
        checks++;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
    endtask

    task automatic test_backpressure();
        send_word(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        if (Q !== 8'h3C || Valid !== 1'b1) begin
            errors++; $display("FAIL bp_first: got q=%h v=%b expected q=3c v=1", Q, Valid);
        end
        checks++;
        send_word(8'hFF, 1'b0, 1'b0, -1, 1'b0);
        if (ob !== 1'b0) begin errors++; $display("FAIL bp_ovr_early: got %b expected 0", ob); end
        checks++;
        if (Overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr: got %b expected 1", Overrun); end
        checks++;
        if (Q !== 8'h3C || Valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got q=%h v=%b expected q=3c v=1", Q, Valid);
        end
        checks++;
        tick();
        if (Overrun !== 1'b0) begin errors++; $display("FAIL bp_ovr_pulse: got %b expected 0", Overrun); end
        checks++;
        if (Q !== 8'h3C || Valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold2: got q=%h v=%b expected q=3c v=1", Q, Valid);
        end
        checks++;
    endtask

    task automatic test_same_edge();
        // 8'h3C is still pending from the backpressure scenario.
        send_word(8'h81, 1'b0, 1'b1, -1, 1'b0);
        if (vb !== 1'b1) begin errors++; $display("FAIL handoff_pending: got %b expected 1", vb); end
        checks++;
        if (Q !== 8'h81 || Valid !== 1'b1) begin
            errors++; $display("FAIL handoff_word: got q=%h v=%b expected q=81 v=1", Q, Valid);
        end
        checks++;
        if (Overrun !== 1'b0) begin errors++; $display("FAIL handoff_ovr: got %b expected 0", Overrun); end
        checks++;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        if (Valid !== 1'b0) begin errors++; $display("FAIL handoff_drop: got %b expected 0", Valid); end
        checks++;
    endtask

    task automatic test_back_to_back();
        send_word(8'h5A, 1'b1, 1'b1, -1, 1'b0);
        if (Q !== 8'h5A || Valid !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got q=%h v=%b expected q=5a v=1", Q, Valid);
        end
        checks++;
        send_word(8'hC3, 1'b1, 1'b1, -1, 1'b0);
        if (vb !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b expected 0", vb); end
        checks++;
        if (Q !== 8'hC3 || Valid !== 1'b1 || Overrun !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got q=%h v=%b o=%b expected q=c3 v=1 o=0", Q, Valid, Overrun);
        end
        checks++;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_word(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0, -1, 1'b0);
        #2 Rst_n = 1'b0;
        #1;
        if (Q !== 8'h00 || Valid !== 1'b0 || Overrun !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got q=%h v=%b o=%b expected q=00 v=0 o=0", Q, Valid, Overrun);
        end
        checks++;
        #3 Rst_n = 1'b1;
        tick();
        // Partial word, then reset: the three bits must be discarded.
        for (int i = 0; i < 3; i++) begin
            D = 1'b1; DEn = 1'b1;
            tick();
        end
        DEn = 1'b0;
        #2 Rst_n = 1'b0;
        #3 Rst_n = 1'b1;
        tick();
        send_word(8'h96, 1'b1, 1'b1, -1, 1'b0);
        if (Q !== 8'h96 || Valid !== 1'b1) begin
            errors++; $display("FAIL midrst_realign: got q=%h v=%b expected q=96 v=1", Q, Valid);
        end
        checks++;
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        send_word(8'h07, 1'b1, 1'b1, -1, 1'b0);
        if (Q !== 8'h07 || Valid !== 1'b1 || ParErr !== 1'b0) begin
            errors++; $display("FAIL par_good: got q=%h v=%b pe=%b expected q=07 v=1 pe=0", Q, Valid, ParErr);
        end
        checks++;
        send_word(8'h07, 1'b1, 1'b1, -1, 1'b1);
        if (Q !== 8'h07 || Valid !== 1'b1 || ParErr !== 1'b1) begin
            errors++; $display("FAIL par_bad: got q=%h v=%b pe=%b expected q=07 v=1 pe=1", Q, Valid, ParErr);
        end
        checks++;
        tick();
        if (ParErr !== 1'b1 || Valid !== 1'b1) begin
            errors++; $display("FAIL par_hold: got pe=%b v=%b expected pe=1 v=1", ParErr, Valid);
        end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_backpressure();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_deser
`default_nettype wire
